// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin request arbiter.
// Holds the FSM encoding and a one-hot to index helper used by RTL and bench.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N        = 4;
    localparam int ARB_MAX_HOLD = 8;

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic int onehot_to_idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating search: first request at or after start, skipping excl.
// Latency 0; no flow control, pure function of its inputs.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    input  logic [N-1:0]    excl,
    output logic [N-1:0]    pick,
    output logic            found
);

    logic [N-1:0]    cand;
    logic [IDXW-1:0] j;

    assign cand = req & ~excl;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = IDXW'((int'(start) + i) % N);
            if (!found && cand[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with max-hold preemption, registered one-hot grant plus index.
// Latency 1 cycle req->gnt; no backpressure, requesters hold req level until served.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDXW     = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx
);

    localparam int              HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    arb_state_t      state;
    logic [IDXW-1:0] ptr;
    logic [HW-1:0]   hold_cnt;

    logic [IDXW-1:0] nxt_ptr;
    logic [IDXW-1:0] pick_start;
    logic [N-1:0]    excl;
    logic [N-1:0]    pick;
    logic            found;
    logic [IDXW-1:0] pick_idx;
    logic            own_req;

    // While granted, the search starts just past the owner and never re-picks it.
    always_comb begin
        nxt_ptr    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        pick_start = (state == GRANT) ? nxt_ptr : ptr;
        excl       = (state == GRANT) ? gnt : '0;
        own_req    = |(req & gnt);
        pick_idx   = IDXW'(onehot_to_idx(32'(pick)));
    end

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .start (pick_start),
        .excl  (excl),
        .pick  (pick),
        .found (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gnt       <= pick;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= pick_idx;
                        hold_cnt  <= HW'(1);
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_req) begin
                        ptr <= nxt_ptr;
                        if (found) begin
                            gnt      <= pick;
                            gnt_idx  <= pick_idx;
                            hold_cnt <= HW'(1);
                        end else begin
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            gnt_idx   <= '0;
                            hold_cnt  <= '0;
                            state     <= IDLE;
                        end
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (found) begin
                        // Hold budget spent and someone else waits: hand over.
                        ptr      <= nxt_ptr;
                        gnt      <= pick;
                        gnt_idx  <= pick_idx;
                        hold_cnt <= HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
